// File: rtl/trig_event_capture.sv
// trig_event_capture: sticky per-channel event flags and saturating occurrence counts with atomic host snapshot
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   trig_in      - per-channel event inputs, synchronous to clk
//   snap         - host snapshot request pulse, ignored while busy
//   clear_counts - zeroes live counters and overflow flags
//   count_sel    - channel whose snapshotted count appears on count_out
//   snap_busy    - high from snapshot acceptance until the valid pulse ends
//   snap_valid   - one-cycle pulse when snapshot registers have been updated
//   trig_snap    - sticky event flags captured at the last snapshot
//   ovf_snap     - counter-saturated flags captured at the last snapshot
//   count_out    - registered snapshotted count of channel count_sel
module trig_event_capture #(
    parameter int N_TRIG = 16,
    parameter int CNT_W  = 16,
    parameter int EDGE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_TRIG-1:0]         trig_in,
    input  logic                      snap,
    input  logic                      clear_counts,
    input  logic [$clog2(N_TRIG)-1:0] count_sel,
    output logic                      snap_busy,
    output logic                      snap_valid,
    output logic [N_TRIG-1:0]         trig_snap,
    output logic [N_TRIG-1:0]         ovf_snap,
    output logic [CNT_W-1:0]          count_out
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
    state_t            state_q, state_d;
    logic [N_TRIG-1:0] prev_q, sticky_q, sticky_d, ovf_q, ovf_d, ev;
    logic [CNT_W-1:0]  cnt_q [N_TRIG];
    logic [CNT_W-1:0]  cnt_d [N_TRIG];
    logic [CNT_W-1:0]  cnt_snap_q [N_TRIG];
    logic              capture;
    always_comb begin
        ev       = (EDGE != 0) ? (trig_in & ~prev_q) : trig_in;
        capture  = (state_q == CAPTURE);
        state_d  = (state_q == IDLE) ? (snap ? CAPTURE : IDLE) : (capture ? DONE : IDLE);
        // events in the capture cycle go into this snapshot, not the next epoch
        sticky_d = capture ? '0 : (sticky_q | ev);
        ovf_d    = '0;
        cnt_d    = cnt_q;
        for (int i = 0; i < N_TRIG; i++) begin
            // clear wins over a same-cycle event; an event at all-ones is lost and flagged
            cnt_d[i] = clear_counts ? '0 : (ev[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
            ovf_d[i] = !clear_counts && (ovf_q[i] || (ev[i] && (&cnt_q[i])));
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snap_busy  <= 1'b0;
            snap_valid <= 1'b0;
            prev_q     <= '0;
            sticky_q   <= '0;
            ovf_q      <= '0;
            cnt_q      <= '{default: '0};
            cnt_snap_q <= '{default: '0};
            trig_snap  <= '0;
            ovf_snap   <= '0;
            count_out  <= '0;
        end else begin
            state_q    <= state_d;
            snap_busy  <= (state_d != IDLE);
            snap_valid <= (state_d == DONE);
            prev_q     <= trig_in;
            sticky_q   <= sticky_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            if (capture) begin
                trig_snap  <= sticky_q | ev;
                ovf_snap   <= ovf_d;
                cnt_snap_q <= cnt_d;
            end
            count_out <= (32'(count_sel) < N_TRIG) ? cnt_snap_q[count_sel] : '0;
        end
    end
endmodule
